wb_commit_unit: RTL and testbench

WB_COMMIT_UNIT -- requirements
Module: wb_commit_unit

---
 rtl/wb_commit_unit_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/wb_commit_unit.sv | 146 ++++++++++++++
 tb/tb_wb_commit_unit.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_unit_pkg.sv
// Shared constants for the writeback commit unit: defaults and load-size encodings.
package wb_commit_unit_pkg;

  localparam int unsigned DEF_WORD_WIDTH     = 32;
  localparam int unsigned DEF_REG_FILE_DEPTH = 4;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } mem_size_e;

  // Number of meaningful bits a load of the given size returns.
  function automatic logic [6:0] lane_bits(input logic [1:0] size, input int unsigned word_width);
    case (size)
      SZ_BYTE: lane_bits = 7'd8;
      SZ_HALF: lane_bits = 7'd16;
      SZ_WORD: lane_bits = 7'd32;
      default: lane_bits = 7'(word_width);
    endcase
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-channel {dst, value} queue with wrap-bit pointers and a pending-dst lookup.
module wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DST_W = 4,
  parameter int unsigned VAL_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [DST_W-1:0] push_dst_i,
  input  logic [VAL_W-1:0] push_val_i,
  input  logic             pop_i,
  input  logic [DST_W-1:0] chk_reg_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [DST_W-1:0] head_dst_o,
  output logic [VAL_W-1:0] head_val_o,
  output logic             chk_hit_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]    count;
  logic [AW-1:0]    idx;
  logic             do_push, do_pop;
  logic [DST_W-1:0] dst_mem_q [DEPTH];
  logic [VAL_W-1:0] val_mem_q [DEPTH];

  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o    = (wr_q == rd_q);
  assign count      = wr_q - rd_q;
  assign head_dst_o = dst_mem_q[rd_q[AW-1:0]];
  assign head_val_o = val_mem_q[rd_q[AW-1:0]];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Payload storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      dst_mem_q[wr_q[AW-1:0]] <= push_dst_i;
      val_mem_q[wr_q[AW-1:0]] <= push_val_i;
    end
  end

  always_comb begin
    chk_hit_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_q[AW-1:0] + AW'(i);
      if ((PW'(i) < count) && (dst_mem_q[idx] == chk_reg_i)) chk_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: queues ALU results and aligned load data, then commits one
// entry per cycle to the register file using round-robin arbitration.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int unsigned REG_FILE_DEPTH = DEF_REG_FILE_DEPTH,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               alu_valid,
  output logic                               alu_ready,
  input  logic [REG_FILE_DEPTH-1:0]          alu_dst,
  input  logic [WORD_WIDTH-1:0]              alu_res,
  input  logic                               mem_valid,
  output logic                               mem_ready,
  input  logic [REG_FILE_DEPTH-1:0]          mem_dst,
  input  logic [WORD_WIDTH-1:0]              mem_data,
  input  logic [1:0]                         mem_size,
  input  logic                               mem_signed,
  input  logic [$clog2(WORD_WIDTH/8)-1:0]    mem_offset,
  output logic                               WB_en_out,
  output logic [REG_FILE_DEPTH-1:0]          WB_Dest,
  output logic [WORD_WIDTH-1:0]              WB_Value,
  input  logic [REG_FILE_DEPTH-1:0]          chk_reg,
  output logic                               chk_hit,
  output logic                               busy
);

  localparam int unsigned OW = $clog2(WORD_WIDTH / 8);

  logic                      alu_full, alu_empty, alu_hit;
  logic                      mem_full, mem_empty, mem_hit;
  logic [REG_FILE_DEPTH-1:0] alu_head_dst, mem_head_dst;
  logic [WORD_WIDTH-1:0]     alu_head_val, mem_head_val;
  logic                      grant_alu, grant_mem;

  logic [OW-1:0]             off_al;
  logic [6:0]                lane_w;
  logic [WORD_WIDTH-1:0]     shifted, lane_mask, load_val;
  logic                      sign_bit;

  logic                      wb_en_q, wb_en_d;
  logic [REG_FILE_DEPTH-1:0] wb_dest_q, wb_dest_d;
  logic [WORD_WIDTH-1:0]     wb_val_q, wb_val_d;
  logic                      rr_mem_last_q, rr_mem_last_d;

  assign alu_ready = !alu_full;
  assign mem_ready = !mem_full;

  // Load alignment: shift the addressed lane to bit 0, then mask and extend.
  always_comb begin
    off_al = mem_offset;
    lane_w = lane_bits(mem_size, WORD_WIDTH);
    case (mem_size_e'(mem_size))
      SZ_BYTE: off_al = mem_offset;
      SZ_HALF: off_al[0] = 1'b0;
      SZ_WORD: off_al[1:0] = 2'b00;
      default: off_al = '0;
    endcase
    shifted   = mem_data >> {off_al, 3'b000};
    lane_mask = {WORD_WIDTH{1'b1}} >> (7'(WORD_WIDTH) - lane_w);
    sign_bit  = mem_signed && |(shifted & (lane_mask ^ (lane_mask >> 1)));
    load_val  = (shifted & lane_mask) | (sign_bit ? ~lane_mask : '0);
  end

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DST_W (REG_FILE_DEPTH),
    .VAL_W (WORD_WIDTH)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (alu_valid && alu_ready),
    .push_dst_i (alu_dst),
    .push_val_i (alu_res),
    .pop_i      (grant_alu),
    .chk_reg_i  (chk_reg),
    .full_o     (alu_full),
    .empty_o    (alu_empty),
    .head_dst_o (alu_head_dst),
    .head_val_o (alu_head_val),
    .chk_hit_o  (alu_hit)
  );

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DST_W (REG_FILE_DEPTH),
    .VAL_W (WORD_WIDTH)
  ) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (mem_valid && mem_ready),
    .push_dst_i (mem_dst),
    .push_val_i (load_val),
    .pop_i      (grant_mem),
    .chk_reg_i  (chk_reg),
    .full_o     (mem_full),
    .empty_o    (mem_empty),
    .head_dst_o (mem_head_dst),
    .head_val_o (mem_head_val),
    .chk_hit_o  (mem_hit)
  );

  // Round-robin: when both queues hold work, the channel not served last time wins.
  always_comb begin
    grant_alu     = !alu_empty && (mem_empty || rr_mem_last_q);
    grant_mem     = !mem_empty && !grant_alu;
    wb_en_d       = grant_alu || grant_mem;
    wb_dest_d     = wb_dest_q;
    wb_val_d      = wb_val_q;
    rr_mem_last_d = rr_mem_last_q;
    if (grant_alu) begin
      wb_dest_d     = alu_head_dst;
      wb_val_d      = alu_head_val;
      rr_mem_last_d = 1'b0;
    end else if (grant_mem) begin
      wb_dest_d     = mem_head_dst;
      wb_val_d      = mem_head_val;
      rr_mem_last_d = 1'b1;
    end
  end

  // Resetting rr to "MEM served last" lets ALU win the first contested cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q       <= 1'b0;
      wb_dest_q     <= '0;
      wb_val_q      <= '0;
      rr_mem_last_q <= 1'b1;
    end else begin
      wb_en_q       <= wb_en_d;
      wb_dest_q     <= wb_dest_d;
      wb_val_q      <= wb_val_d;
      rr_mem_last_q <= rr_mem_last_d;
    end
  end

  assign WB_en_out = wb_en_q;
  assign WB_Dest   = wb_dest_q;
  assign WB_Value  = wb_val_q;
  assign chk_hit   = alu_hit || mem_hit || (wb_en_q && (wb_dest_q == chk_reg));
  assign busy      = !alu_empty || !mem_empty || wb_en_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Bench for wb_commit_unit: a channel/arbiter model fills a commit scoreboard that a
// negedge monitor drains, plus one task per scenario with its own directed checks.
module tb_wb_commit_unit;

  localparam int unsigned WW = 32;
  localparam int unsigned RD = 4;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          alu_valid = 1'b0, alu_ready;
  logic [RD-1:0] alu_dst = '0;
  logic [WW-1:0] alu_res = '0;
  logic          mem_valid = 1'b0, mem_ready;
  logic [RD-1:0] mem_dst = '0;
  logic [WW-1:0] mem_data = '0;
  logic [1:0]    mem_size = 2'b00;
  logic          mem_signed = 1'b0;
  logic [1:0]    mem_offset = 2'b00;
  logic          WB_en_out;
  logic [RD-1:0] WB_Dest;
  logic [WW-1:0] WB_Value;
  logic [RD-1:0] chk_reg = '0;
  logic          chk_hit;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RD-1:0] dst;
    logic [WW-1:0] val;
  } entry_t;

  entry_t alu_m[$];
  entry_t mem_m[$];
  entry_t exp_q[$];
  logic   rr_mem_last_m = 1'b1;
  logic   exp_en_m = 1'b0;

  always #5 clk = ~clk;

  wb_commit_unit #(
    .WORD_WIDTH     (WW),
    .REG_FILE_DEPTH (RD),
    .FIFO_DEPTH     (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_dst    (alu_dst),
    .alu_res    (alu_res),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_dst    (mem_dst),
    .mem_data   (mem_data),
    .mem_size   (mem_size),
    .mem_signed (mem_signed),
    .mem_offset (mem_offset),
    .WB_en_out  (WB_en_out),
    .WB_Dest    (WB_Dest),
    .WB_Value   (WB_Value),
    .chk_reg    (chk_reg),
    .chk_hit    (chk_hit),
    .busy       (busy)
  );

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   return sgn ? {{24{b[7]}}, b} : {24'h0, b};
      2'b01:   return sgn ? {{16{h[15]}}, h} : {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Reference model of both queues and the arbiter.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_m.delete();
      mem_m.delete();
      exp_q.delete();
      rr_mem_last_m = 1'b1;
      exp_en_m      = 1'b0;
    end else begin
      bit ap, mp, ga, gm;
      ap = alu_valid && (alu_m.size() < FD);
      mp = mem_valid && (mem_m.size() < FD);
      ga = (alu_m.size() != 0) && ((mem_m.size() == 0) || rr_mem_last_m);
      gm = (mem_m.size() != 0) && !ga;
      exp_en_m = ga || gm;
      if (ga) begin
        exp_q.push_back(alu_m.pop_front());
        rr_mem_last_m = 1'b0;
      end
      if (gm) begin
        exp_q.push_back(mem_m.pop_front());
        rr_mem_last_m = 1'b1;
      end
      if (ap) alu_m.push_back({alu_dst, alu_res});
      if (mp) mem_m.push_back({mem_dst, model_load(mem_data, mem_size, mem_signed, mem_offset)});
    end
  end

  // Scoreboard drain and per-cycle status checks.
  always @(negedge clk) begin
    entry_t e;
    checks++;
    if (WB_en_out !== exp_en_m) begin
      errors++;
      $display("FAIL mon_wb_en actual %0b expected %0b t=%0t", WB_en_out, exp_en_m, $time);
    end
    if (exp_en_m && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (WB_en_out === 1'b1) begin
        checks++;
        if ({WB_Dest, WB_Value} !== e) begin
          errors++;
          $display("FAIL mon_commit actual dst=%0d val=%h expected dst=%0d val=%h t=%0t",
                   WB_Dest, WB_Value, e.dst, e.val, $time);
        end
      end
    end
    checks++;
    if (alu_ready !== (alu_m.size() < FD) || mem_ready !== (mem_m.size() < FD)) begin
      errors++;
      $display("FAIL mon_ready actual alu=%0b mem=%0b expected alu=%0b mem=%0b t=%0t",
               alu_ready, mem_ready, alu_m.size() < FD, mem_m.size() < FD, $time);
    end
    checks++;
    if (busy !== ((alu_m.size() != 0) || (mem_m.size() != 0) || exp_en_m)) begin
      errors++;
      $display("FAIL mon_busy actual %0b t=%0t", busy, $time);
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (WB_en_out !== 1'b0 || WB_Dest !== '0 || WB_Value !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs actual en=%0b dst=%0d val=%h busy=%0b expected 0/0/0/0",
               WB_en_out, WB_Dest, WB_Value, busy);
    end
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready actual alu=%0b mem=%0b hit=%0b expected 1/1/0",
               alu_ready, mem_ready, chk_hit);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_alu_single();
    @(negedge clk);
    alu_valid = 1'b1;
    alu_dst   = 4'd3;
    alu_res   = 32'h1234_5678;
    @(negedge clk);
    alu_valid = 1'b0;
    checks++;
    if (WB_en_out !== 1'b0) begin
      errors++;
      $display("FAIL alu_latency_early actual en=%0b expected 0", WB_en_out);
    end
    @(negedge clk);
    checks++;
    if (WB_en_out !== 1'b1 || WB_Dest !== 4'd3 || WB_Value !== 32'h1234_5678) begin
      errors++;
      $display("FAIL alu_commit actual en=%0b dst=%0d val=%h expected 1/3/12345678",
               WB_en_out, WB_Dest, WB_Value);
    end
    @(negedge clk);
    checks++;
    if (WB_en_out !== 1'b0) begin
      errors++;
      $display("FAIL alu_one_cycle actual en=%0b expected 0", WB_en_out);
    end
  endtask

  task automatic test_load_extract();
    logic [1:0]  sz  [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  off [8] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd3};
    logic        sgn [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] exv [8] = '{32'hFFFF_FFFF, 32'hFFFF_FF80, 32'h0000_7F01, 32'hFFFF_80FF,
                             32'h0000_007F, 32'h80FF_7F01, 32'h80FF_7F01, 32'h0000_80FF};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      mem_valid  = 1'b1;
      mem_dst    = 4'(i + 1);
      mem_data   = 32'h80FF_7F01;
      mem_size   = sz[i];
      mem_offset = off[i];
      mem_signed = sgn[i];
      @(negedge clk);
      mem_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (WB_en_out !== 1'b1 || WB_Dest !== 4'(i + 1) || WB_Value !== exv[i]) begin
        errors++;
        $display("FAIL load_%0d actual en=%0b dst=%0d val=%h expected en=1 dst=%0d val=%h",
                 i, WB_en_out, WB_Dest, WB_Value, i + 1, exv[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [RD-1:0] seen[$];
    int na = 0;
    int nm = 0;
    do_reset();
    mem_size   = 2'b11;
    mem_signed = 1'b0;
    mem_offset = 2'd0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (WB_en_out === 1'b1) seen.push_back(WB_Dest);
      if (seen.size() == 16) break;
      if (alu_ready && na < 8) begin
        alu_valid = 1'b1;
        alu_dst   = 4'(na);
        alu_res   = 32'hA000_0000 + 32'(na);
        na++;
      end else alu_valid = 1'b0;
      if (mem_ready && nm < 8) begin
        mem_valid = 1'b1;
        mem_dst   = 4'(8 + nm);
        mem_data  = 32'hB000_0000 + 32'(nm);
        nm++;
      end else mem_valid = 1'b0;
    end
    idle_inputs();
    checks++;
    if (seen.size() != 16) begin
      errors++;
      $display("FAIL b2b_count actual %0d commits expected 16", seen.size());
    end
    for (int j = 0; j < seen.size(); j++) begin
      logic [RD-1:0] want;
      want = (j % 2 == 0) ? 4'(j / 2) : 4'(8 + j / 2);
      checks++;
      if (seen[j] !== want) begin
        errors++;
        $display("FAIL b2b_order_%0d actual dst=%0d expected dst=%0d", j, seen[j], want);
      end
    end
  endtask

  task automatic test_full();
    bit full_seen = 1'b0;
    bit popped = 1'b0;
    bit seen15 = 1'b0;
    int na = 0;
    logic [RD-1:0] last_dst = '0;
    do_reset();
    @(negedge clk);
    mem_valid = 1'b1;
    mem_dst   = 4'd9;
    mem_size  = 2'b11;
    mem_data  = 32'h0000_000C;
    for (int c = 0; c < 40; c++) begin
      if (!alu_ready) begin
        full_seen = 1'b1;
        break;
      end
      alu_valid = 1'b1;
      alu_dst   = 4'(1 + na % 7);
      alu_res   = 32'hC000_0000 + 32'(na);
      last_dst  = alu_dst;
      na++;
      @(negedge clk);
    end
    checks++;
    if (!full_seen) begin
      errors++;
      $display("FAIL full_reached actual alu_ready=%0b expected 0", alu_ready);
    end
    chk_reg = last_dst;
    #1;
    checks++;
    if (chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL full_tail_hit actual %0b expected 1", chk_hit);
    end
    alu_valid = 1'b1;
    alu_dst   = 4'd15;
    alu_res   = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      alu_valid = 1'b0;
      if (WB_en_out === 1'b1 && WB_Dest !== 4'd9) begin
        checks++;
        if (alu_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_ready_rise actual %0b expected 1", alu_ready);
        end
        popped = 1'b1;
        break;
      end
      checks++;
      if (alu_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_ready_early actual %0b expected 0", alu_ready);
      end
    end
    checks++;
    if (!popped) begin
      errors++;
      $display("FAIL full_alu_pop actual none expected an ALU commit");
    end
    mem_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (WB_en_out === 1'b1 && WB_Dest === 4'd15) seen15 = 1'b1;
      if (busy === 1'b0) break;
    end
    checks++;
    if (seen15 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_drain actual seen15=%0b busy=%0b expected 0/0", seen15, busy);
    end
  endtask

  task automatic test_chk_hit();
    @(negedge clk);
    chk_reg = 4'd5;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_idle actual %0b expected 0", chk_hit);
    end
    alu_valid = 1'b1;
    alu_dst   = 4'd5;
    alu_res   = 32'h0000_0055;
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    checks++;
    if (chk_hit !== 1'b1 || WB_en_out !== 1'b0) begin
      errors++;
      $display("FAIL chk_queued actual hit=%0b en=%0b expected 1/0", chk_hit, WB_en_out);
    end
    chk_reg = 4'd6;
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_other actual %0b expected 0", chk_hit);
    end
    chk_reg = 4'd5;
    @(negedge clk);
    #1;
    checks++;
    if (chk_hit !== 1'b1 || WB_en_out !== 1'b1 || WB_Dest !== 4'd5) begin
      errors++;
      $display("FAIL chk_output actual hit=%0b en=%0b dst=%0d expected 1/1/5",
               chk_hit, WB_en_out, WB_Dest);
    end
    @(negedge clk);
    #1;
    checks++;
    if (chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL chk_retired actual %0b expected 0", chk_hit);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    alu_valid = 1'b1;
    alu_dst   = 4'd2;
    alu_res   = 32'h2222_2222;
    mem_valid = 1'b1;
    mem_dst   = 4'd12;
    mem_size  = 2'b11;
    mem_data  = 32'hCCCC_0012;
    @(negedge clk);
    alu_dst  = 4'd4;
    mem_dst  = 4'd13;
    mem_data = 32'hCCCC_0013;
    @(negedge clk);
    idle_inputs();
    chk_reg = 4'd13;
    #1;
    checks++;
    if (chk_hit !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre actual hit=%0b busy=%0b expected 1/1", chk_hit, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (WB_en_out !== 1'b0 || WB_Dest !== '0 || WB_Value !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out actual en=%0b dst=%0d val=%h busy=%0b expected 0/0/0/0",
               WB_en_out, WB_Dest, WB_Value, busy);
    end
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready actual alu=%0b mem=%0b hit=%0b expected 1/1/0",
               alu_ready, mem_ready, chk_hit);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (WB_en_out !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost_%0d actual en=%0b expected 0", c, WB_en_out);
      end
    end
    alu_valid = 1'b1;
    alu_dst   = 4'd7;
    alu_res   = 32'h7777_0007;
    @(negedge clk);
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (WB_en_out !== 1'b1 || WB_Dest !== 4'd7 || WB_Value !== 32'h7777_0007) begin
      errors++;
      $display("FAIL mid_after actual en=%0b dst=%0d val=%h expected 1/7/77770007",
               WB_en_out, WB_Dest, WB_Value);
    end
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_load_extract();
    test_back_to_back();
    test_full();
    test_chk_hit();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
